bit_packer: RTL and testbench

- Downstream consumer of the single-bit registered stream produced by the clear-or-pass register stage and its `+1` output register.
- Collects accepted bits into WIDTH-bit words and presents each word on a one-entry valid/ready output.
- The upstream stream cannot stall, so a completed word with no free output slot is dropped and flagged.
- A clear input, matching the upstream `ct` semantics, aborts the partial word.

---
 rtl/bit_packer_pkg.sv | 21 ++
 rtl/bp_out_slot.sv | 45 ++++
 rtl/bit_packer.sv | 88 ++++++++
 tb/tb_bit_packer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/bit_packer_pkg.sv
// ============================================================================
// Module : bit_packer_pkg
// Brief  : Shared constants, count-width helper and types for bit_packer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package bit_packer_pkg;

  localparam int BP_WIDTH_DEFAULT = 8;

  // Counter must hold 0..width inclusive.
  function automatic int bp_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

  typedef logic [bp_cnt_w(BP_WIDTH_DEFAULT)-1:0] bp_cnt_t;

endpackage : bit_packer_pkg

`default_nettype wire

// File: rtl/bp_out_slot.sv
// ============================================================================
// Module : bp_out_slot
// Brief  : One-entry valid/ready holding register for completed words.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bp_out_slot
  import bit_packer_pkg::*;
#(
  parameter int WIDTH = BP_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic             free,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  // A draining entry may be refilled in the same cycle.
  assign free      = ~r_valid | out_ready;
  assign out_data  = r_data;
  assign out_valid = r_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (load) begin
      r_data  <= load_data;
      r_valid <= 1'b1;
    end else if (r_valid && out_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule : bp_out_slot

`default_nettype wire

// File: rtl/bit_packer.sv
// ============================================================================
// Module : bit_packer
// Brief  : Packs an accepted single-bit stream into WIDTH-bit words.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bit_packer
  import bit_packer_pkg::*;
#(
  parameter int WIDTH     = BP_WIDTH_DEFAULT,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic                          in_bit,
  input  logic                          clr,
  output logic [WIDTH-1:0]              out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [bp_cnt_w(WIDTH)-1:0]    bit_count,
  output logic                          overflow
);

  localparam int CW = bp_cnt_w(WIDTH);

  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_cnt;
  logic             r_overflow;

  logic [WIDTH-1:0] w_shift_next;
  logic             w_accept;
  logic             w_last;
  logic             w_free;
  logic             w_load;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_shift_next = {r_shift[WIDTH-2:0], in_bit};
    end else begin : g_lsb_first
      assign w_shift_next = {in_bit, r_shift[WIDTH-1:1]};
    end
  endgenerate

  // Control depends only on in_valid/clr/out_ready, never on in_bit.
  assign w_accept = in_valid & ~clr;
  assign w_last   = w_accept & (r_cnt == CW'(WIDTH - 1));
  assign w_load   = w_last & w_free;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift    <= '0;
      r_cnt      <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (clr || w_last) begin
        r_shift <= '0;
        r_cnt   <= '0;
      end else if (w_accept) begin
        r_shift <= w_shift_next;
        r_cnt   <= r_cnt + CW'(1);
      end
      if (w_last && !w_free) begin
        r_overflow <= 1'b1;
      end
    end
  end

  bp_out_slot #(
    .WIDTH (WIDTH)
  ) u_out_slot (
    .clk       (clk),
    .rst       (rst),
    .load      (w_load),
    .load_data (w_shift_next),
    .out_ready (out_ready),
    .free      (w_free),
    .out_data  (out_data),
    .out_valid (out_valid)
  );

  assign bit_count = r_cnt;
  assign overflow  = r_overflow;

endmodule : bit_packer

`default_nettype wire

// File: tb/tb_bit_packer.sv
// ============================================================================
// Module : tb_bit_packer
// Brief  : Self-checking bench for both bit orders of bit_packer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bit_packer;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_bit;
  logic         clr;
  logic         out_ready;
  logic [W-1:0] od_m, od_l;
  logic         ov_m, ov_l;
  logic [3:0]   bc_m, bc_l;
  logic         of_m, of_l;

  int n_vec  = 0;
  int n_miss = 0;

  bit           q[$];
  logic [W-1:0] m_data_m, m_data_l;
  logic         m_valid;
  logic         m_ovf;

  typedef struct {
    logic [W-1:0] word;
    logic [W-1:0] exp_m;
    logic [W-1:0] exp_l;
  } vec_t;

  vec_t tbl[6];

  bit_packer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .clr(clr),
    .out_data(od_m), .out_valid(ov_m), .out_ready(out_ready),
    .bit_count(bc_m), .overflow(of_m)
  );

  bit_packer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .clr(clr),
    .out_data(od_l), .out_valid(ov_l), .out_ready(out_ready),
    .bit_count(bc_l), .overflow(of_l)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: partial word kept as a list of bits, word built arithmetically.
  task automatic model_step();
    bit           free;
    logic [W-1:0] wm, wl;
    if (rst) begin
      q.delete();
      m_data_m = '0;
      m_data_l = '0;
      m_valid  = 1'b0;
      m_ovf    = 1'b0;
      return;
    end
    free = !m_valid || out_ready;
    if (m_valid && out_ready) m_valid = 1'b0;
    if (clr) begin
      q.delete();
    end else if (in_valid) begin
      q.push_back(in_bit);
      if (q.size() == W) begin
        wm = '0;
        wl = '0;
        for (int i = 0; i < W; i++) begin
          wm = wm + (W'(q[i]) << (W - 1 - i));
          wl = wl + (W'(q[i]) << i);
        end
        if (free) begin
          m_data_m = wm;
          m_data_l = wl;
          m_valid  = 1'b1;
        end else begin
          m_ovf = 1'b1;
        end
        q.delete();
      end
    end
  endtask

  task automatic model_check();
    chk("valid_msb",  ov_m, m_valid);
    chk("valid_lsb",  ov_l, m_valid);
    chk("count_msb",  bc_m, q.size());
    chk("count_lsb",  bc_l, q.size());
    chk("ovf_msb",    of_m, m_ovf);
    chk("ovf_lsb",    of_l, m_ovf);
    chk("data_msb",   od_m, m_data_m);
    chk("data_lsb",   od_l, m_data_l);
  endtask

  task automatic cycle(input logic r, input logic v, input logic b,
                       input logic c, input logic rd);
    rst       = r;
    in_valid  = v;
    in_bit    = b;
    clr       = c;
    out_ready = rd;
    model_step();
    @(posedge clk);
    #1;
    model_check();
  endtask

  // Bits go out in w[W-1] .. w[0] order; ready may differ on the final bit.
  task automatic feed_word(input logic [W-1:0] w, input logic rd, input logic rd_last);
    for (int i = W - 1; i >= 0; i--) begin
      cycle(1'b0, 1'b1, w[i], 1'b0, (i == 0) ? rd_last : rd);
    end
  endtask

  initial begin
    tbl[0] = '{8'hB2, 8'hB2, 8'h4D};
    tbl[1] = '{8'hFF, 8'hFF, 8'hFF};
    tbl[2] = '{8'hA5, 8'hA5, 8'hA5};
    tbl[3] = '{8'h0F, 8'h0F, 8'hF0};
    tbl[4] = '{8'h01, 8'h01, 8'h80};
    tbl[5] = '{8'h3C, 8'h3C, 8'h3C};

    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_data", od_m, 8'h00);
    chk("rst_valid", ov_m, 1'b0);
    chk("rst_count", bc_m, 4'd0);
    chk("rst_ovf", of_m, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Table: each word must appear exactly one cycle after its last bit.
    for (int t = 0; t < 6; t++) begin
      for (int i = W - 1; i >= 1; i--) cycle(1'b0, 1'b1, tbl[t].word[i], 1'b0, 1'b1);
      chk("tbl_pre_valid", ov_m, 1'b0);
      chk("tbl_pre_count", bc_m, 4'd7);
      cycle(1'b0, 1'b1, tbl[t].word[0], 1'b0, 1'b1);
      chk("tbl_valid", ov_m, 1'b1);
      chk("tbl_msb", od_m, tbl[t].exp_m);
      chk("tbl_lsb", od_l, tbl[t].exp_l);
      chk("tbl_count", bc_m, 4'd0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end

    // Clear wins over a coincident bit and discards the partial word.
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("clr_count", bc_m, 4'd0);
    feed_word(8'hFF, 1'b1, 1'b1);
    chk("clr_word", od_m, 8'hFF);
    chk("clr_ovf", of_m, 1'b0);

    // Full slot: second word is dropped and flagged.
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    feed_word(8'hA5, 1'b0, 1'b0);
    feed_word(8'h3C, 1'b0, 1'b0);
    chk("ovf_data", od_m, 8'hA5);
    chk("ovf_valid", ov_m, 1'b1);
    chk("ovf_flag", of_m, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovf_drain", ov_m, 1'b0);
    chk("ovf_sticky", of_m, 1'b1);

    // Drain and refill in the same cycle.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    feed_word(8'h55, 1'b0, 1'b0);
    feed_word(8'h0F, 1'b0, 1'b1);
    chk("refill_valid", ov_m, 1'b1);
    chk("refill_msb", od_m, 8'h0F);
    chk("refill_lsb", od_l, 8'hF0);
    chk("refill_ovf", of_m, 1'b0);

    // Reset mid-word with a word pending.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("mrst_data", od_m, 8'h00);
    chk("mrst_valid", ov_m, 1'b0);
    chk("mrst_count", bc_m, 4'd0);
    feed_word(8'hC3, 1'b1, 1'b1);
    chk("mrst_word", od_m, 8'hC3);
    chk("mrst_valid2", ov_m, 1'b1);

    // Random traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      cycle(($urandom_range(0, 299) == 0),
            ($urandom_range(0, 3) != 0),
            1'($urandom),
            ($urandom_range(0, 19) == 0),
            1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_bit_packer

`default_nettype wire
